// File: rtl/game_sequencer_if.sv
// Bundles the control, sequence-memory, timer and display signals of the
// memory-game sequencer. The sequencer side uses the master modport, the
// surrounding system (player, memory, timer, display) uses slave.
interface game_sequencer_if;
    logic       start_game;
    logic       abort;
    logic       btn_valid;
    logic [3:0] btn_tile;
    logic [4:0] seq_addr;
    logic [3:0] seq_data;
    logic       timer_start;
    logic       timer_stop;
    logic [5:0] timer_max;
    logic [1:0] timer_speed;
    logic       timer_done;
    logic       show_valid;
    logic [3:0] show_tile;
    logic [4:0] level;
    logic       game_over;
    logic       win;
    logic [3:0] state;

    modport master (
        input  start_game, abort, btn_valid, btn_tile, seq_data, timer_done,
        output seq_addr, timer_start, timer_stop, timer_max, timer_speed,
               show_valid, show_tile, level, game_over, win, state
    );

    modport slave (
        output start_game, abort, btn_valid, btn_tile, seq_data, timer_done,
        input  seq_addr, timer_start, timer_stop, timer_max, timer_speed,
               show_valid, show_tile, level, game_over, win, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Memory-game sequencer: replays a tile sequence of growing length from an
// external memory, then checks the player's presses against it. Tile on/off
// and response windows are timed by an external Timer. All outputs registered.
module game_sequencer #(
    parameter logic [5:0] SHOW_TIME  = 6'd2,
    parameter logic [5:0] GAP_TIME   = 6'd1,
    parameter logic [5:0] INPUT_TIME = 6'd10,
    parameter logic [4:0] MAX_LEVEL  = 5'd16
) (
    input logic               clock,
    input logic               reset,
    game_sequencer_if.master  bus
);
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SHOW_FETCH = 4'd1;
    localparam logic [3:0] S_SHOW       = 4'd2;
    localparam logic [3:0] S_GAP        = 4'd3;
    localparam logic [3:0] S_IN_FETCH   = 4'd4;
    localparam logic [3:0] S_WAIT_IN    = 4'd5;
    localparam logic [3:0] S_LEVEL_DONE = 4'd6;
    localparam logic [3:0] S_OVER       = 4'd7;

    // Timer speed grows every four levels and saturates at 3.
    function automatic logic [1:0] speed_for_level(input logic [4:0] lvl);
        logic [2:0] quarter;
        quarter = lvl[4:2];
        if (quarter > 3'd3) begin
            return 2'd3;
        end else begin
            return quarter[1:0];
        end
    endfunction

    logic [3:0] state_r;
    logic [4:0] level_r;
    logic [4:0] idx_r;
    logic       fetch_wait_r;
    logic [3:0] expected_r;
    logic [4:0] seq_addr_r;
    logic [3:0] show_tile_r;
    logic       show_valid_r;
    logic       timer_start_r;
    logic       timer_stop_r;
    logic [5:0] timer_max_r;
    logic [1:0] timer_speed_r;
    logic       game_over_r;
    logic       win_r;

    logic       timer_done_s;
    logic       last_idx_s;

    // A done flag seen while a new start is going out belongs to the previous phase.
    assign timer_done_s = bus.timer_done & ~timer_start_r;
    assign last_idx_s   = (idx_r == (level_r - 5'd1));

    // Game FSM with all registered outputs; abort overrides every other event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            level_r       <= 5'd0;
            idx_r         <= 5'd0;
            fetch_wait_r  <= 1'b0;
            expected_r    <= 4'd0;
            seq_addr_r    <= 5'd0;
            show_tile_r   <= 4'd0;
            show_valid_r  <= 1'b0;
            timer_start_r <= 1'b0;
            timer_stop_r  <= 1'b0;
            timer_max_r   <= 6'd0;
            timer_speed_r <= 2'd0;
            game_over_r   <= 1'b0;
            win_r         <= 1'b0;
        end else begin
            timer_start_r <= 1'b0;
            timer_stop_r  <= 1'b0;
            if (bus.abort) begin
                timer_stop_r <= 1'b1;
                show_valid_r <= 1'b0;
                game_over_r  <= 1'b0;
                win_r        <= 1'b0;
                fetch_wait_r <= 1'b0;
                state_r      <= S_IDLE;
            end else begin
                case (state_r)
                    S_IDLE, S_OVER: begin
                        if (bus.start_game) begin
                            level_r       <= 5'd1;
                            timer_speed_r <= speed_for_level(5'd1);
                            idx_r         <= 5'd0;
                            seq_addr_r    <= 5'd0;
                            fetch_wait_r  <= 1'b0;
                            game_over_r   <= 1'b0;
                            win_r         <= 1'b0;
                            state_r       <= S_SHOW_FETCH;
                        end
                    end
                    S_SHOW_FETCH: begin
                        // First cycle lets the memory read; second cycle consumes the data.
                        if (!fetch_wait_r) begin
                            fetch_wait_r <= 1'b1;
                        end else begin
                            fetch_wait_r  <= 1'b0;
                            show_tile_r   <= bus.seq_data;
                            show_valid_r  <= 1'b1;
                            timer_start_r <= 1'b1;
                            timer_max_r   <= SHOW_TIME;
                            state_r       <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (timer_done_s) begin
                            show_valid_r  <= 1'b0;
                            timer_start_r <= 1'b1;
                            timer_max_r   <= GAP_TIME;
                            state_r       <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (timer_done_s) begin
                            if (last_idx_s) begin
                                idx_r      <= 5'd0;
                                seq_addr_r <= 5'd0;
                                state_r    <= S_IN_FETCH;
                            end else begin
                                idx_r      <= idx_r + 5'd1;
                                seq_addr_r <= idx_r + 5'd1;
                                state_r    <= S_SHOW_FETCH;
                            end
                        end
                    end
                    S_IN_FETCH: begin
                        if (!fetch_wait_r) begin
                            fetch_wait_r <= 1'b1;
                        end else begin
                            fetch_wait_r  <= 1'b0;
                            expected_r    <= bus.seq_data;
                            timer_start_r <= 1'b1;
                            timer_max_r   <= INPUT_TIME;
                            state_r       <= S_WAIT_IN;
                        end
                    end
                    S_WAIT_IN: begin
                        // A press outranks a simultaneous timeout.
                        if (bus.btn_valid) begin
                            timer_stop_r <= 1'b1;
                            if (bus.btn_tile == expected_r) begin
                                if (last_idx_s) begin
                                    state_r <= S_LEVEL_DONE;
                                end else begin
                                    idx_r      <= idx_r + 5'd1;
                                    seq_addr_r <= idx_r + 5'd1;
                                    state_r    <= S_IN_FETCH;
                                end
                            end else begin
                                game_over_r <= 1'b1;
                                win_r       <= 1'b0;
                                state_r     <= S_OVER;
                            end
                        end else if (timer_done_s) begin
                            game_over_r <= 1'b1;
                            win_r       <= 1'b0;
                            state_r     <= S_OVER;
                        end
                    end
                    S_LEVEL_DONE: begin
                        if (level_r == MAX_LEVEL) begin
                            game_over_r <= 1'b1;
                            win_r       <= 1'b1;
                            state_r     <= S_OVER;
                        end else begin
                            level_r       <= level_r + 5'd1;
                            timer_speed_r <= speed_for_level(level_r + 5'd1);
                            idx_r         <= 5'd0;
                            seq_addr_r    <= 5'd0;
                            state_r       <= S_SHOW_FETCH;
                        end
                    end
                    default: begin
                        fetch_wait_r <= 1'b0;
                        state_r      <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.seq_addr    = seq_addr_r;
    assign bus.timer_start = timer_start_r;
    assign bus.timer_stop  = timer_stop_r;
    assign bus.timer_max   = timer_max_r;
    assign bus.timer_speed = timer_speed_r;
    assign bus.show_valid  = show_valid_r;
    assign bus.show_tile   = show_tile_r;
    assign bus.level       = level_r;
    assign bus.game_over   = game_over_r;
    assign bus.win         = win_r;
    assign bus.state       = state_r;
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter SHOW_TIME, default 6'd2, Timer maxTime for a tile's on-period.
REQ-002 Parameter GAP_TIME, default 6'd1, Timer maxTime for the blank gap between shown tiles.
REQ-003 Parameter INPUT_TIME, default 6'd10, Timer maxTime for each player-response window.
REQ-004 Parameter MAX_LEVEL, default 5'd16, level whose completion is a win (range 1..31).
REQ-005 Port clock  in  1  single system clock; all state updates on the rising edge.
REQ-006 Port reset  in  1  asynchronous, active-low reset.
REQ-007 Port start_game  in  1  one-cycle pulse that begins a new game.
REQ-008 Port abort  in  1  one-cycle pulse that returns the block to IDLE.
REQ-009 Port btn_valid / btn_tile  in  1 / 4  one-cycle player press and the tile pressed.
REQ-010 Port seq_addr / seq_data  out 5 / in 4  sequence-memory read address and data; synchronous read, 1-cycle latency.
REQ-011 Port timer_start / timer_stop  out  1 / 1  one-cycle pulses to the Timer.
REQ-012 Port timer_max / timer_speed  out  6 / 2  Timer maxTime and speed.
REQ-013 Port timer_done  in  1  Timer expiry flag.
REQ-014 Port show_valid / show_tile  out  1 / 4  tile to light and the tile index.
REQ-015 Port level  out  5  current level (sequence length).
REQ-016 Port game_over / win  out  1 / 1  end of game; win=1 when the game ended by completing MAX_LEVEL.
REQ-017 Port state  out  4  current FSM state code, for debug.

Function
REQ-018 The FSM SHALL have states IDLE=0, SHOW_FETCH=1, SHOW=2, GAP=3, IN_FETCH=4, WAIT_IN=5, LEVEL_DONE=6, OVER=7, and all outputs SHALL be registered.
REQ-019 IDLE: start_game SHALL set level=1, idx=0, game_over=0, win=0, and go to SHOW_FETCH.
REQ-020 SHOW_FETCH: seq_addr=idx; after 1 cycle: latch seq_data into show_tile; pulse timer_start with timer_max=SHOW_TIME; go to SHOW.
REQ-021 SHOW: show_valid=1; on timer_done: show_valid=0; pulse timer_start with timer_max=GAP_TIME; go to GAP.
REQ-022 GAP: on timer_done: if idx==level-1, set idx=0 and go to IN_FETCH; otherwise idx+1 and go to SHOW_FETCH.
REQ-023 IN_FETCH: seq_addr=idx; after 1 cycle: latch seq_data as expected; pulse timer_start with timer_max=INPUT_TIME; go to WAIT_IN.
REQ-024 WAIT_IN, btn_valid: pulse timer_stop; if btn_tile==expected: go to LEVEL_DONE when idx==level-1, else idx+1 and go to IN_FETCH; if btn_tile!=expected: go to OVER with win=0.
REQ-025 WAIT_IN, timer_done with no btn_valid: go to OVER with win=0 (timeout).
REQ-026 WAIT_IN, btn_valid and timer_done in the same cycle: the press SHALL take priority.
REQ-027 LEVEL_DONE: if level==MAX_LEVEL, go to OVER with win=1; otherwise level+1, idx=0, go to SHOW_FETCH.
REQ-028 OVER: game_over=1 held; start_game behaves as in IDLE.
REQ-029 timer_done SHALL be ignored in any cycle where timer_start is high (stale flag from the previous phase).
REQ-030 timer_speed SHALL be min(level>>2, 3), updated with level.
REQ-031 abort in any state SHALL: pulse timer_stop; clear show_valid, game_over, win; go to IDLE. abort SHALL win over every simultaneous event.
REQ-032 btn_valid outside WAIT_IN and start_game outside IDLE/OVER SHALL be ignored.

Reset
REQ-033 While reset=0 the block SHALL be in IDLE with level=0, idx=0, seq_addr=0, show_tile=0, timer_max=0, timer_speed=0, and all 1-bit outputs=0, independent of clock.
REQ-034 If reset is asserted mid-game, the next state after release SHALL be IDLE with no timer_start pulse.

Verification
REQ-035 Reset during SHOW -> all outputs zero immediately, state=0 after release.
REQ-036 start_game, memory[0]=4'd7, Timer model -> show_tile=7 with show_valid for SHOW_TIME ticks, timer_start pulses at SHOW and GAP entry, then state=5.
REQ-037 Level 1, press tile 7 -> timer_stop pulse, LEVEL_DONE, level=2, replay of addresses 0 and 1.
REQ-038 WAIT_IN, press wrong tile 3 (expected 7) -> state=7, game_over=1, win=0.
REQ-039 WAIT_IN, no press until timer_done -> OVER with win=0; correct press in the same cycle as timer_done -> accepted.
REQ-040 MAX_LEVEL=2, complete both levels -> game_over=1, win=1; timer_speed=0 at level 2; abort mid-GAP -> state=0 and a timer_stop pulse.
